// File: rtl/sched_pkg.sv
// Shared types and constants for the task dispatcher.
package sched_pkg;

    localparam int unsigned SCHED_D_W   = 12;
    localparam int unsigned SCHED_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_RUN   = 3'd4
    } sched_state_e;

endpackage

// File: rtl/sched_wdog.sv
// RUN-state watchdog: cleared on RUN entry, counts enabled cycles, flags the last allowed cycle.
module sched_wdog #(
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic CLK,
    input  logic CLR_N,
    input  logic clear,
    input  logic count_en,
    output logic expire_c
);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + WDOG_W'(1);
        end
    end

    assign expire_c = count_en && (count == WDOG_W'(WDOG_LIMIT - 1));

endmodule

// File: rtl/sched_dispatch.sv
// Task dispatcher: fetches one scheduler FIFO entry at a time and offers it to the CPU.
// Optional RUN-state watchdog is built in when SCHED_WDOG_EN is defined.
module sched_dispatch
    import sched_pkg::*;
#(
    parameter int unsigned D_W        = SCHED_D_W,
    parameter int unsigned WDOG_W     = 16,
    parameter int unsigned WDOG_LIMIT = 1000
) (
    input  logic                   CLK,
    input  logic                   CLR_N,
    input  logic                   EN,
    input  logic                   FIFO_EMPTY,
    output logic                   FIFO_RD,
    input  logic [D_W-1:0]         FIFO_D,
    output logic                   TASK_VALID,
    output logic [D_W-1:0]         TASK_ID,
    input  logic                   TASK_READY,
    input  logic                   TASK_DONE,
    output logic                   BUSY,
    output logic                   TIMEOUT,
    output logic [SCHED_CNT_W-1:0] TASK_CNT
);

    sched_state_e state;
    logic         wdog_expire_c;

    if (D_W == 0 || WDOG_W == 0 || WDOG_LIMIT < 2 ||
        64'(WDOG_LIMIT) > (64'd1 << WDOG_W)) begin : g_bad_cfg
        $error("sched_dispatch: invalid D_W / WDOG_W / WDOG_LIMIT combination");
    end

`ifdef SCHED_WDOG_EN
    logic wdog_clear_c;
    logic wdog_count_c;

    assign wdog_clear_c = (state == S_ISSUE) && TASK_READY;
    assign wdog_count_c = (state == S_RUN);

    sched_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .CLK      (CLK),
        .CLR_N    (CLR_N),
        .clear    (wdog_clear_c),
        .count_en (wdog_count_c),
        .expire_c (wdog_expire_c)
    );

    // A completion landing on the expiry cycle suppresses the timeout
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            TIMEOUT <= 1'b0;
        end else begin
            TIMEOUT <= wdog_expire_c && !TASK_DONE;
        end
    end
`else
    assign wdog_expire_c = 1'b0;
    assign TIMEOUT       = 1'b0;
`endif

    // Dispatch FSM; all outputs are registered alongside the state
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state      <= S_IDLE;
            FIFO_RD    <= 1'b0;
            TASK_VALID <= 1'b0;
            TASK_ID    <= '0;
            BUSY       <= 1'b0;
            TASK_CNT   <= '0;
        end else begin
            FIFO_RD <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (EN && !FIFO_EMPTY) begin
                        state   <= S_FETCH;
                        FIFO_RD <= 1'b1;
                        BUSY    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    // Read data is valid on FIFO_D the cycle after the strobe
                    state      <= S_ISSUE;
                    TASK_ID    <= FIFO_D;
                    TASK_VALID <= 1'b1;
                end
                S_ISSUE: begin
                    if (TASK_READY) begin
                        state      <= S_RUN;
                        TASK_VALID <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (TASK_DONE) begin
                        state    <= S_IDLE;
                        BUSY     <= 1'b0;
                        TASK_CNT <= TASK_CNT + SCHED_CNT_W'(1);
                    end else if (wdog_expire_c) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    TASK_VALID <= 1'b0;
                    BUSY       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sched_dispatch.sv
// Self-checking bench for sched_dispatch: directed scenarios plus a randomized run against a queue model.
module tb_sched_dispatch;

    localparam int unsigned D_W        = 12;
    localparam int unsigned WDOG_W     = 16;
    localparam int unsigned WDOG_LIMIT = 8;

    logic           CLK = 1'b0;
    logic           CLR_N;
    logic           EN;
    logic           FIFO_EMPTY;
    logic           FIFO_RD;
    logic [D_W-1:0] FIFO_D;
    logic           TASK_VALID;
    logic [D_W-1:0] TASK_ID;
    logic           TASK_READY;
    logic           TASK_DONE;
    logic           BUSY;
    logic           TIMEOUT;
    logic [7:0]     TASK_CNT;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int model_cnt;
    int rd_base;

    logic [D_W-1:0] fifo_q[$];
    logic [D_W-1:0] exp_q[$];
    int             rd_cyc_q[$];

    always #5 CLK = ~CLK;

    sched_dispatch #(
        .D_W        (D_W),
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .CLK        (CLK),
        .CLR_N      (CLR_N),
        .EN         (EN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD    (FIFO_RD),
        .FIFO_D     (FIFO_D),
        .TASK_VALID (TASK_VALID),
        .TASK_ID    (TASK_ID),
        .TASK_READY (TASK_READY),
        .TASK_DONE  (TASK_DONE),
        .BUSY       (BUSY),
        .TIMEOUT    (TIMEOUT),
        .TASK_CNT   (TASK_CNT)
    );

    // Scheduler FIFO model: a read strobe pops one entry onto FIFO_D for the next cycle
    always @(posedge CLK) begin
        cyc++;
        if (FIFO_RD === 1'b1) begin
            rd_cyc_q.push_back(cyc);
            if (fifo_q.size() != 0) FIFO_D <= fifo_q.pop_front();
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no end of test, expected $finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        FIFO_EMPTY = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [D_W-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        FIFO_EMPTY = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        CLR_N = 1'b0;
        repeat (cycles) tick();
        check("rst_busy",    32'(BUSY),       32'd0);
        check("rst_valid",   32'(TASK_VALID), 32'd0);
        check("rst_id",      32'(TASK_ID),    32'd0);
        check("rst_fifo_rd", 32'(FIFO_RD),    32'd0);
        check("rst_timeout", 32'(TIMEOUT),    32'd0);
        check("rst_cnt",     32'(TASK_CNT),   32'd0);
        CLR_N = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        FIFO_EMPTY = 1'b1;
        model_cnt  = 0;
        rd_base    = rd_cyc_q.size();
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 40 && TASK_VALID !== 1'b1; k++) tick();
        check("valid_seen", 32'(TASK_VALID), 32'd1);
    endtask

    // One task from offer to completion; the expected id is the oldest un-dispatched push
    task automatic run_task(input int ready_dly, input int done_dly, input bit tie_ready, input bit drop_en);
        logic [D_W-1:0] exp_id;
        int             rd_before;
        exp_id = exp_q.pop_front();
        wait_valid();
        check("task_id",    32'(TASK_ID), 32'(exp_id));
        check("busy_issue", 32'(BUSY),    32'd1);
        if (drop_en) EN = 1'b0;
        rd_before = rd_cyc_q.size();
        if (!tie_ready) begin
            for (int i = 0; i < ready_dly; i++) begin
                tick();
                check("valid_hold", 32'(TASK_VALID), 32'd1);
                check("id_hold",    32'(TASK_ID),    32'(exp_id));
            end
            TASK_READY = 1'b1;
            tick();
            TASK_READY = 1'b0;
        end else begin
            tick();
        end
        check("valid_drop", 32'(TASK_VALID),      32'd0);
        check("busy_run",   32'(BUSY),            32'd1);
        check("no_refetch", 32'(rd_cyc_q.size()), 32'(rd_before));
        for (int i = 0; i < done_dly; i++) begin
            tick();
            check("run_wait",   32'(BUSY),    32'd1);
            check("no_timeout", 32'(TIMEOUT), 32'd0);
        end
        TASK_DONE = 1'b1;
        tick();
        TASK_DONE = 1'b0;
        model_cnt = (model_cnt + 1) % 256;
        check("busy_idle",    32'(BUSY),     32'd0);
        check("timeout_idle", 32'(TIMEOUT),  32'd0);
        check("task_cnt",     32'(TASK_CNT), 32'(model_cnt));
        check("id_kept",      32'(TASK_ID),  32'(exp_id));
        if (drop_en) begin
            tick();
            tick();
            check("en_blocks_busy", 32'(BUSY),            32'd0);
            check("en_blocks_rd",   32'(rd_cyc_q.size()), 32'(rd_before));
            EN = 1'b1;
        end
    endtask

    initial begin
        CLR_N      = 1'b0;
        EN         = 1'b0;
        FIFO_EMPTY = 1'b1;
        FIFO_D     = '0;
        TASK_READY = 1'b0;
        TASK_DONE  = 1'b0;
        model_cnt  = 0;
        rd_base    = 0;

        do_reset(2);

        // Single preloaded entry, READY and DONE one cycle late
        EN = 1'b1;
        push(12'h123);
        run_task(1, 1, 1'b0, 1'b0);
        check("single_rd_pulses", 32'(rd_cyc_q.size() - rd_base), 32'd1);

        // Three back-to-back entries with READY tied high: in order, 5-cycle fetch spacing
        do_reset(1);
        EN = 1'b1;
        push(12'h001);
        push(12'h002);
        push(12'h003);
        TASK_READY = 1'b1;
        run_task(0, 0, 1'b1, 1'b0);
        run_task(0, 0, 1'b1, 1'b0);
        run_task(0, 0, 1'b1, 1'b0);
        TASK_READY = 1'b0;
        repeat (3) tick();
        check("three_rd_pulses", 32'(rd_cyc_q.size() - rd_base), 32'd3);
        check("three_idle_busy", 32'(BUSY), 32'd0);
        check("three_cnt",       32'(TASK_CNT), 32'd3);
        if (rd_cyc_q.size() >= rd_base + 3) begin
            check("fetch_spacing_1", 32'(rd_cyc_q[rd_base+1] - rd_cyc_q[rd_base]),   32'd5);
            check("fetch_spacing_2", 32'(rd_cyc_q[rd_base+2] - rd_cyc_q[rd_base+1]), 32'd5);
        end

        // READY withheld 10 cycles in ISSUE while another entry waits; then EN drop mid-task
        push(12'h0AB);
        push(12'h0CD);
        run_task(10, 0, 1'b0, 1'b0);
        run_task(0, 2, 1'b0, 1'b1);

`ifdef SCHED_WDOG_EN
        // No DONE: TIMEOUT pulses 8 cycles after RUN entry, count unchanged
        push(12'h5A5);
        void'(exp_q.pop_front());
        wait_valid();
        TASK_READY = 1'b1;
        tick();
        TASK_READY = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("wdog_pre_timeout", 32'(TIMEOUT), 32'd0);
            check("wdog_pre_busy",    32'(BUSY),    32'd1);
        end
        tick();
        check("wdog_timeout", 32'(TIMEOUT),  32'd1);
        check("wdog_idle",    32'(BUSY),     32'd0);
        check("wdog_cnt",     32'(TASK_CNT), 32'(model_cnt));
        tick();
        check("wdog_pulse_end", 32'(TIMEOUT), 32'd0);
        // DONE on the expiry cycle completes normally
        push(12'h6B6);
        run_task(0, 7, 1'b0, 1'b0);
`else
        // Without the watchdog RUN waits as long as it takes
        push(12'h5A5);
        run_task(0, 25, 1'b0, 1'b0);
`endif

        // Randomized dispatch long enough to wrap TASK_CNT past 255
        for (int t = 0; t < 260; t++) begin
            while (fifo_q.size() < 2) push(D_W'($urandom));
            run_task(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     1'b0, ($urandom_range(0, 7) == 0));
        end

        // DONE pulse while IDLE must not count
        EN = 1'b0;
        repeat (2) tick();
        check("idle_before_done", 32'(BUSY), 32'd0);
        TASK_DONE = 1'b1;
        tick();
        TASK_DONE = 1'b0;
        tick();
        check("idle_done_cnt",  32'(TASK_CNT), 32'(model_cnt));
        check("idle_done_busy", 32'(BUSY),     32'd0);

        // Reset while a task is running drops it
        EN = 1'b1;
        if (fifo_q.size() == 0) push(12'h7C7);
        wait_valid();
        TASK_READY = 1'b1;
        tick();
        TASK_READY = 1'b0;
        tick();
        check("pre_reset_busy", 32'(BUSY), 32'd1);
        do_reset(1);
        tick();
        check("post_reset_busy", 32'(BUSY),       32'd0);
        check("post_reset_rd",   32'(rd_cyc_q.size() - rd_base), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
